// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX/MEM and writeback.
//
// Takes one instruction per cycle from the EX/MEM register. Loads and stores
// go out on an SRAM-like request/response port, and upstream is stalled until
// the access completes. Load data is extracted and extended, then registered
// with the writeback controls as the MEM/WB outputs.
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   in_*                EX/MEM register contents (held stable while stall_o=1)
//   stall_o             freeze PC, IF/ID, ID/EX and EX/MEM this cycle
//   data_req .. wdata   request channel (req, wr, size, addr, wstrb, wdata)
//   data_addr_ok        request accepted this cycle
//   data_data_ok        response / store completion this cycle
//   data_rdata          read data, valid with data_data_ok
//   wb_*                registered MEM/WB outputs
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_res,
  input  logic        in_data_en,
  input  logic [3:0]  in_data_wen,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_ldtype,
  input  logic        in_regwen,
  input  logic [5:0]  in_wreg,
  input  logic [1:0]  in_whilo,
  output logic        stall_o,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_res,
  output logic        wb_regwen,
  output logic [5:0]  wb_wreg,
  output logic [1:0]  wb_whilo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1
  } state_t;

  state_t      state_q, state_d;

  logic        wb_valid_q,  wb_valid_d;
  logic [31:0] wb_pc_q,     wb_pc_d;
  logic [31:0] wb_res_q,    wb_res_d;
  logic        wb_regwen_q, wb_regwen_d;
  logic [5:0]  wb_wreg_q,   wb_wreg_d;
  logic [1:0]  wb_whilo_q,  wb_whilo_d;

  logic        mem_op;
  logic        is_load;
  logic        resp_done;
  logic        commit;

  // Select the addressed byte/halfword and extend it according to ldtype.
  // Reserved ldtype encodings fall through to a full word.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  ldtype);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (ldtype)
      3'b001:  r = {{24{b[7]}}, b};
      3'b010:  r = {24'd0, b};
      3'b011:  r = {{16{h[15]}}, h};
      3'b100:  r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Access size: loads go by ldtype, stores are inferred from the strobes.
  function automatic logic [1:0] req_size(input logic [3:0] wen,
                                          input logic [2:0] ldtype);
    logic [1:0] s;
    if (wen == 4'b0000) begin
      case (ldtype)
        3'b001, 3'b010: s = 2'd0;
        3'b011, 3'b100: s = 2'd1;
        default:        s = 2'd2;
      endcase
    end else begin
      case (wen)
        4'b1111:         s = 2'd2;
        4'b0011, 4'b1100: s = 2'd1;
        default:         s = 2'd0;
      endcase
    end
    return s;
  endfunction

  assign mem_op    = in_valid & in_data_en;
  assign is_load   = in_data_en & ~(|in_data_wen);
  assign resp_done = (state_q == WAIT) & data_data_ok;
  assign commit    = (in_valid & ~in_data_en) | resp_done;

  assign stall_o    = mem_op & ~resp_done;
  assign data_req   = (state_q == IDLE) & mem_op;
  assign data_wr    = |in_data_wen;
  assign data_size  = req_size(in_data_wen, in_ldtype);
  assign data_addr  = in_res;
  assign data_wstrb = in_data_wen;
  assign data_wdata = in_wdata;

  // Next state: data_data_ok is deliberately ignored while IDLE, so a late
  // response to an access abandoned by reset cannot commit anything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_req & data_addr_ok) state_d = WAIT;
      WAIT:    if (data_data_ok)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MEM/WB next values: bubbles clear the valid/write enables only, the
  // remaining fields keep their last committed contents.
  always_comb begin
    wb_valid_d  = 1'b0;
    wb_regwen_d = 1'b0;
    wb_whilo_d  = 2'b00;
    wb_pc_d     = wb_pc_q;
    wb_res_d    = wb_res_q;
    wb_wreg_d   = wb_wreg_q;
    if (commit) begin
      wb_valid_d  = 1'b1;
      wb_pc_d     = in_pc;
      wb_regwen_d = in_regwen;
      wb_wreg_d   = in_wreg;
      wb_whilo_d  = in_whilo;
      wb_res_d    = is_load ? load_extract(data_rdata, in_res[1:0], in_ldtype)
                            : in_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      wb_valid_q  <= 1'b0;
      wb_pc_q     <= 32'd0;
      wb_res_q    <= 32'd0;
      wb_regwen_q <= 1'b0;
      wb_wreg_q   <= 6'd0;
      wb_whilo_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      wb_pc_q     <= wb_pc_d;
      wb_res_q    <= wb_res_d;
      wb_regwen_q <= wb_regwen_d;
      wb_wreg_q   <= wb_wreg_d;
      wb_whilo_q  <= wb_whilo_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_pc     = wb_pc_q;
  assign wb_res    = wb_res_q;
  assign wb_regwen = wb_regwen_q;
  assign wb_wreg   = wb_wreg_q;
  assign wb_whilo  = wb_whilo_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_res;
  logic        in_data_en;
  logic [3:0]  in_data_wen;
  logic [31:0] in_wdata;
  logic [2:0]  in_ldtype;
  logic        in_regwen;
  logic [5:0]  in_wreg;
  logic [1:0]  in_whilo;
  logic        stall_o;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_res;
  logic        wb_regwen;
  logic [5:0]  wb_wreg;
  logic [1:0]  wb_whilo;

  mem_stage dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_pc(in_pc), .in_res(in_res),
    .in_data_en(in_data_en), .in_data_wen(in_data_wen), .in_wdata(in_wdata),
    .in_ldtype(in_ldtype), .in_regwen(in_regwen), .in_wreg(in_wreg),
    .in_whilo(in_whilo), .stall_o(stall_o),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_res(wb_res),
    .wb_regwen(wb_regwen), .wb_wreg(wb_wreg), .wb_whilo(wb_whilo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // 'pending' = an accepted access is awaiting its response.
  bit          live = 0;
  bit          pending = 0;
  logic        m_valid, m_regwen;
  logic [31:0] m_pc, m_res;
  logic [5:0]  m_wreg;
  logic [1:0]  m_whilo;

  function automatic logic [31:0] model_load(input logic [31:0] rd,
                                             input logic [31:0] a,
                                             input logic [2:0] t);
    int unsigned byt, half;
    byt  = (rd >> (a[1:0] * 8)) & 32'hFF;
    half = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
    if (t == 3'd1) return (byt  >= 128)   ? byt  + 32'hFFFF_FF00 : byt;
    if (t == 3'd2) return byt;
    if (t == 3'd3) return (half >= 32768) ? half + 32'hFFFF_0000 : half;
    if (t == 3'd4) return half;
    return rd;
  endfunction

  function automatic logic [1:0] model_size(input logic [3:0] w,
                                            input logic [2:0] t);
    if (w == 4'h0) begin
      if (t == 3'd1 || t == 3'd2) return 2'd0;
      if (t == 3'd3 || t == 3'd4) return 2'd1;
      return 2'd2;
    end
    if (w == 4'hF) return 2'd2;
    if (w == 4'h3 || w == 4'hC) return 2'd1;
    return 2'd0;
  endfunction

  always @(posedge clk) begin
    bit retire;
    if (!resetn) begin
      live = 1; pending = 0;
      m_valid = 0; m_regwen = 0; m_pc = 0; m_res = 0; m_wreg = 0; m_whilo = 0;
    end else begin
      retire = (in_valid && !in_data_en) || (pending && data_data_ok);
      if (retire) begin
        m_valid = 1; m_pc = in_pc; m_regwen = in_regwen; m_wreg = in_wreg;
        m_whilo = in_whilo;
        m_res = (in_data_en && in_data_wen == 0)
                  ? model_load(data_rdata, in_res, in_ldtype) : in_res;
      end else begin
        m_valid = 0; m_regwen = 0; m_whilo = 0;
      end
      if (pending) pending = !data_data_ok;
      else         pending = in_valid && in_data_en && data_addr_ok;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    bit mem, e_req;
    if (live) begin
      mem   = in_valid && in_data_en;
      e_req = mem && !pending;
      check("data_req", {31'd0, data_req}, {31'd0, e_req});
      check("stall_o", {31'd0, stall_o}, {31'd0, mem && !(pending && data_data_ok)});
      if (e_req) begin
        check("data_addr", data_addr, in_res);
        check("data_wr", {31'd0, data_wr}, {31'd0, in_data_wen != 0});
        check("data_size", {30'd0, data_size}, {30'd0, model_size(in_data_wen, in_ldtype)});
        check("data_wstrb", {28'd0, data_wstrb}, {28'd0, in_data_wen});
        check("data_wdata", data_wdata, in_wdata);
      end
      check("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
      check("wb_pc", wb_pc, m_pc);
      check("wb_res", wb_res, m_res);
      check("wb_regwen", {31'd0, wb_regwen}, {31'd0, m_regwen});
      check("wb_wreg", {26'd0, wb_wreg}, {26'd0, m_wreg});
      check("wb_whilo", {30'd0, wb_whilo}, {30'd0, m_whilo});
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] acc_size;
  logic       acc_wr;
  int         stall_cycles;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic [31:0] pc, input logic [31:0] res,
                        input logic [5:0] wreg);
    in_valid = 1; in_pc = pc; in_res = res; in_data_en = 0; in_data_wen = 0;
    in_regwen = 1; in_wreg = wreg; in_whilo = 2'b00;
    tick();
    in_valid = 0;
  endtask

  // Issue a memory op: addr_ok withheld for adly cycles, data_ok k cycles
  // after acceptance. Leaves the bench just after the commit edge.
  task automatic mem_op(input logic [31:0] pc, input logic [31:0] addr,
                        input logic [3:0] wen, input logic [2:0] lt,
                        input logic [31:0] wd, input logic rw,
                        input int adly, input int k, input logic [31:0] rd);
    in_valid = 1; in_pc = pc; in_res = addr; in_data_en = 1; in_data_wen = wen;
    in_ldtype = lt; in_wdata = wd; in_regwen = rw; in_wreg = 6'd9;
    in_whilo = 2'b00; data_rdata = rd; data_data_ok = 0;
    stall_cycles = 0;
    data_addr_ok = 0;
    for (int i = 0; i < adly; i++) begin
      #1; if (stall_o) stall_cycles++;
      tick();
    end
    data_addr_ok = 1;
    #1; acc_size = data_size; acc_wr = data_wr;
    if (stall_o) stall_cycles++;
    tick();
    data_addr_ok = 0;
    for (int i = 1; i < k; i++) begin
      #1; if (stall_o) stall_cycles++;
      tick();
    end
    data_data_ok = 1;
    #1; if (stall_o) stall_cycles++;
    tick();
    data_data_ok = 0; in_valid = 0; in_data_en = 0;
  endtask

  initial begin
    resetn = 0; in_valid = 0; in_pc = 0; in_res = 0; in_data_en = 0;
    in_data_wen = 0; in_wdata = 0; in_ldtype = 0; in_regwen = 0; in_wreg = 0;
    in_whilo = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;

    // Reset with a valid ALU op present
    in_valid = 1; in_pc = 32'h100; in_res = 32'h1234_5678; in_regwen = 1;
    in_wreg = 6'd5; in_whilo = 2'b01;
    tick();
    check("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst wb_res", wb_res, 32'd0);
    check("rst wb_whilo", {30'd0, wb_whilo}, 32'd0);
    resetn = 1;
    tick();
    in_valid = 0;
    check("alu wb_valid", {31'd0, wb_valid}, 32'd1);
    check("alu wb_res", wb_res, 32'h1234_5678);
    check("alu wb_whilo", {30'd0, wb_whilo}, 32'd1);
    tick();

    // LB / LBU at 0x1003
    mem_op(32'h200, 32'h1003, 4'h0, 3'd1, 0, 1, 0, 1, 32'h80FF_FF00);
    check("lb wb_valid", {31'd0, wb_valid}, 32'd1);
    check("lb wb_res", wb_res, 32'hFFFF_FF80);
    check("lb stall cycles", stall_cycles, 32'd1);
    check("lb size", {30'd0, acc_size}, 32'd0);
    mem_op(32'h204, 32'h1003, 4'h0, 3'd2, 0, 1, 0, 1, 32'h80FF_FF00);
    check("lbu wb_res", wb_res, 32'h0000_0080);

    // Halfword loads
    mem_op(32'h208, 32'h2002, 4'h0, 3'd3, 0, 1, 0, 2, 32'h8001_1234);
    check("lh wb_res", wb_res, 32'hFFFF_8001);
    check("lh size", {30'd0, acc_size}, 32'd1);
    mem_op(32'h20C, 32'h2000, 4'h0, 3'd4, 0, 1, 0, 1, 32'h8001_1234);
    check("lhu wb_res", wb_res, 32'h0000_1234);
    mem_op(32'h210, 32'h2004, 4'h0, 3'd0, 0, 1, 0, 1, 32'hCAFE_F00D);
    check("lw wb_res", wb_res, 32'hCAFE_F00D);
    mem_op(32'h214, 32'h2001, 4'h0, 3'd7, 0, 1, 0, 1, 32'h1357_9BDF);
    check("reserved ldtype wb_res", wb_res, 32'h1357_9BDF);

    // SW with delayed acceptance, back-to-back after the ALU op
    alu_op(32'h218, 32'h0000_00AA, 6'd3);
    mem_op(32'h21C, 32'h3000, 4'hF, 3'd0, 32'hDEAD_BEEF, 0, 3, 2, 32'h0);
    check("sw wb_res", wb_res, 32'h3000);
    check("sw wb_regwen", {31'd0, wb_regwen}, 32'd0);
    check("sw wb_valid", {31'd0, wb_valid}, 32'd1);
    check("sw size", {30'd0, acc_size}, 32'd2);
    check("sw wr", {31'd0, acc_wr}, 32'd1);
    check("sw stall cycles", stall_cycles, 32'd5);

    // Byte and halfword stores
    mem_op(32'h220, 32'h3002, 4'b0100, 3'd0, 32'h5555_5555, 0, 0, 1, 32'h0);
    check("sb size", {30'd0, acc_size}, 32'd0);
    mem_op(32'h224, 32'h3002, 4'b1100, 3'd0, 32'h7777_7777, 0, 0, 1, 32'h0);
    check("sh size", {30'd0, acc_size}, 32'd1);

    // addr_ok and data_ok together in IDLE: only acceptance counts
    in_valid = 1; in_pc = 32'h228; in_res = 32'h4000; in_data_en = 1;
    in_data_wen = 0; in_ldtype = 3'd0; in_regwen = 1; data_rdata = 32'h0BAD_F00D;
    data_addr_ok = 1; data_data_ok = 1;
    tick();
    check("same-cycle no commit", {31'd0, wb_valid}, 32'd0);
    data_addr_ok = 0;
    #1; check("same-cycle stall low", {31'd0, stall_o}, 32'd0);
    tick();
    data_data_ok = 0; in_valid = 0;
    check("same-cycle commit", wb_res, 32'h0BAD_F00D);

    // Abandon on reset while in WAIT
    in_valid = 1; in_pc = 32'h22C; in_res = 32'h40; in_data_en = 1;
    in_data_wen = 0; in_ldtype = 3'd0; data_addr_ok = 1;
    tick();
    data_addr_ok = 0;
    resetn = 0;
    tick();
    resetn = 1; in_valid = 0; in_data_en = 0;
    tick();
    data_data_ok = 1; data_rdata = 32'hFFFF_FFFF;
    tick();
    data_data_ok = 0;
    check("abandon wb_valid", {31'd0, wb_valid}, 32'd0);
    in_valid = 1; in_data_en = 1; in_res = 32'h44;
    #1; check("abandon idle req", {31'd0, data_req}, 32'd1);
    in_valid = 0; in_data_en = 0;
    tick();
    alu_op(32'h230, 32'h0000_0BEE, 6'd7);
    check("post-abandon alu", wb_res, 32'h0000_0BEE);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
